gate_exhaustive_tester: RTL and testbench

Synthesizable, parametrised successor to the two-input NAND stimulus bench: an on-chip sequencer that applies every one of the 2^N_INPUTS input patterns to an N-input logic gate under test, waits a configurable pipeline latency, and compares the gate output against a built-in reference model for a selectable function (NAND/NOR/AND/OR/XOR). It reports pass/fail, an error count and the first failing vector. It sits beside a gate-level DUT in modeling exercises, so the same check runs in simulation and on hardware.

---
 rtl/gate_tester_pkg.sv | 27 ++
 rtl/gate_exhaustive_tester_if.sv | 24 ++
 rtl/gate_ref_model.sv | 28 ++
 rtl/gate_exhaustive_tester.sv | 172 +++++++++++++++++
 tb/tb_gate_exhaustive_tester.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/gate_tester_pkg.sv
// Shared definitions for the exhaustive gate tester: function codes, FSM states, limits.
package gate_tester_pkg;

    localparam int MAX_INPUTS  = 8;
    localparam int MAX_LATENCY = 7;

    typedef enum int {
        GF_NAND = 0,
        GF_NOR  = 1,
        GF_AND  = 2,
        GF_OR   = 3,
        GF_XOR  = 4
    } gate_func_e;

    typedef enum logic [2:0] {
        TS_IDLE  = 3'd0,
        TS_APPLY = 3'd1,
        TS_WAIT  = 3'd2,
        TS_CHECK = 3'd3,
        TS_DONE  = 3'd4
    } tester_state_e;

    function automatic bit gate_func_legal(input int f);
        return (f >= int'(GF_NAND)) && (f <= int'(GF_XOR));
    endfunction

endpackage

// File: rtl/gate_exhaustive_tester_if.sv
// Handshake and result bundle between the gate tester (master) and its environment (slave).
interface gate_exhaustive_tester_if #(
    parameter int N_INPUTS = 2
);
    logic                start;
    logic                dut_y;
    logic [N_INPUTS-1:0] stim;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_INPUTS:0]   err_count;
    logic [N_INPUTS-1:0] first_fail_vec;
    logic                first_fail_valid;

    modport master (
        input  start, dut_y,
        output stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, dut_y,
        input  stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference gate: reduces vec with the selected operator, NAND/NOR inverted.
module gate_ref_model
    import gate_tester_pkg::*;
#(
    parameter int N_INPUTS  = 2,
    parameter int GATE_FUNC = 0
) (
    input  logic [N_INPUTS-1:0] vec,
    output logic                y
);

    if (!gate_func_legal(GATE_FUNC)) begin : g_bad_func
        $error("gate_ref_model: GATE_FUNC must be 0..4");
    end

    // Reduction of the input pattern for the configured function
    always_comb begin
        case (GATE_FUNC)
            int'(GF_NAND): y = ~(&vec);
            int'(GF_NOR):  y = ~(|vec);
            int'(GF_AND):  y = &vec;
            int'(GF_OR):   y = |vec;
            int'(GF_XOR):  y = ^vec;
            default:       y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_exhaustive_tester.sv
// Sequencer that sweeps all input patterns through a gate under test and scores its output.
// Optional macro GATE_TESTER_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_exhaustive_tester
    import gate_tester_pkg::*;
#(
    parameter int N_INPUTS    = 2,
    parameter int GATE_FUNC   = 0,
    parameter int DUT_LATENCY = 0
) (
    input logic                     clk,
    input logic                     rst,
    gate_exhaustive_tester_if.master bus
);

    if (N_INPUTS < 1 || N_INPUTS > MAX_INPUTS) begin : g_bad_n
        $error("gate_exhaustive_tester: N_INPUTS must be 1..8");
    end
    if (DUT_LATENCY < 0 || DUT_LATENCY > MAX_LATENCY) begin : g_bad_lat
        $error("gate_exhaustive_tester: DUT_LATENCY must be 0..7");
    end

    localparam logic [2:0] ST_IDLE  = TS_IDLE;
    localparam logic [2:0] ST_APPLY = TS_APPLY;
    localparam logic [2:0] ST_WAIT  = TS_WAIT;
    localparam logic [2:0] ST_CHECK = TS_CHECK;
    localparam logic [2:0] ST_DONE  = TS_DONE;

    localparam logic [N_INPUTS-1:0] STIM_ONES = {N_INPUTS{1'b1}};
    localparam logic [N_INPUTS-1:0] STIM_ONE  = N_INPUTS'(1'b1);
    localparam logic [N_INPUTS:0]   ERR_ONE   = (N_INPUTS + 1)'(1'b1);
    localparam int                  LAT_INIT_I = (DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0;
    localparam logic [2:0]          LAT_INIT   = LAT_INIT_I[2:0];

    logic [2:0]          state_r,   state_s;
    logic [N_INPUTS-1:0] stim_r,    stim_s;
    logic [2:0]          lat_cnt_r, lat_cnt_s;
    logic [N_INPUTS:0]   err_cnt_r, err_cnt_s;
    logic [N_INPUTS-1:0] ffv_r,     ffv_s;
    logic                ffvalid_r, ffvalid_s;
    logic                busy_r,    busy_s;
    logic                done_r,    done_s;
    logic                pass_r,    pass_s;
    logic                expected_s;
    logic                mismatch_s;
    logic                last_s;

    gate_ref_model #(
        .N_INPUTS  (N_INPUTS),
        .GATE_FUNC (GATE_FUNC)
    ) u_ref (
        .vec (stim_r),
        .y   (expected_s)
    );

    assign mismatch_s = (bus.dut_y != expected_s);

    // End-of-run decision for the pattern currently being checked
    always_comb begin
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
        last_s = (stim_r == STIM_ONES) || mismatch_s;
`else
        last_s = (stim_r == STIM_ONES);
`endif
    end

    // Next-state and bookkeeping logic for the sweep
    always_comb begin
        state_s   = state_r;
        stim_s    = stim_r;
        lat_cnt_s = lat_cnt_r;
        err_cnt_s = err_cnt_r;
        ffv_s     = ffv_r;
        ffvalid_s = ffvalid_r;
        busy_s    = busy_r;
        done_s    = done_r;
        pass_s    = pass_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_s   = ST_APPLY;
                    stim_s    = '0;
                    err_cnt_s = '0;
                    ffv_s     = '0;
                    ffvalid_s = 1'b0;
                    busy_s    = 1'b1;
                    done_s    = 1'b0;
                    pass_s    = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_APPLY: begin
                if (DUT_LATENCY > 0) begin
                    state_s   = ST_WAIT;
                    lat_cnt_s = LAT_INIT;
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r == 3'd0) begin
                    state_s = ST_CHECK;
                end else begin
                    lat_cnt_s = lat_cnt_r - 3'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_cnt_s = err_cnt_r + ERR_ONE;
                    if (!ffvalid_r) begin
                        ffv_s     = stim_r;
                        ffvalid_s = 1'b1;
                    end else begin
                        ffv_s = ffv_r;
                    end
                end else begin
                    err_cnt_s = err_cnt_r;
                end
                // Results become visible together with the fall of busy
                if (last_s) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_cnt_s == '0);
                end else begin
                    state_s = ST_APPLY;
                    stim_s  = stim_r + STIM_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
                pass_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            stim_r    <= '0;
            lat_cnt_r <= 3'd0;
            err_cnt_r <= '0;
            ffv_r     <= '0;
            ffvalid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            stim_r    <= stim_s;
            lat_cnt_r <= lat_cnt_s;
            err_cnt_r <= err_cnt_s;
            ffv_r     <= ffv_s;
            ffvalid_r <= ffvalid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
        end
    end

    assign bus.stim             = stim_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.pass             = pass_r;
    assign bus.err_count        = err_cnt_r;
    assign bus.first_fail_vec   = ffv_r;
    assign bus.first_fail_valid = ffvalid_r;

endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// Bench for gate_exhaustive_tester: two configurations driven by modelled gates with injected faults.
module tb_gate_exhaustive_tester;
    import gate_tester_pkg::*;

    localparam int NA = 2, FA = 0, LA = 0;
    localparam int NB = 3, FB = 1, LB = 2;
    localparam int K_BUSY = 0, K_DONE = 1, K_PASS = 2, K_ERR = 3, K_STIM = 4, K_FFV = 5, K_FFVAL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_exhaustive_tester_if #(.N_INPUTS(NA)) ifa ();
    gate_exhaustive_tester_if #(.N_INPUTS(NB)) ifb ();

    gate_exhaustive_tester #(.N_INPUTS(NA), .GATE_FUNC(FA), .DUT_LATENCY(LA)) u_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    gate_exhaustive_tester #(.N_INPUTS(NB), .GATE_FUNC(FB), .DUT_LATENCY(LB)) u_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mode_a   = 0;   // 0 ideal, 1 stuck-1, 2 stuck-0, 3 invert patterns in mask
    int mode_b   = 0;
    int del_b    = 2;
    logic [3:0] mask_a = 4'd0;
    logic [7:0] mask_b = 8'd0;
    logic [2:0] pipe [0:3];
    logic [2:0] dly_b;

    function automatic bit ref_gate(input int func, input int n, input int p);
        int all;
        all = (1 << n) - 1;
        case (func)
            0:       return p != all;
            1:       return p == 0;
            2:       return p == all;
            3:       return p != 0;
            default: return ($countones(p) % 2) == 1;
        endcase
    endfunction

    assign ifa.dut_y = (mode_a == 1) ? 1'b1 :
                       (mode_a == 2) ? 1'b0 :
                       (ref_gate(FA, NA, int'(ifa.stim)) ^ ((mode_a == 3) && mask_a[ifa.stim]));

    // Registered gate model for configuration B: del_b stages from stim to dut_y
    always @(posedge clk) begin
        pipe[0] <= ifb.stim;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign dly_b     = pipe[del_b-1];
    assign ifb.dut_y = ref_gate(FB, NB, int'(dly_b)) ^ ((mode_b == 3) && mask_b[dly_b]);

    function automatic int obs(input int s, input int k);
        case (k)
            K_BUSY:  return s ? int'(ifb.busy)             : int'(ifa.busy);
            K_DONE:  return s ? int'(ifb.done)             : int'(ifa.done);
            K_PASS:  return s ? int'(ifb.pass)             : int'(ifa.pass);
            K_ERR:   return s ? int'(ifb.err_count)        : int'(ifa.err_count);
            K_STIM:  return s ? int'(ifb.stim)             : int'(ifa.stim);
            K_FFV:   return s ? int'(ifb.first_fail_vec)   : int'(ifa.first_fail_vec);
            default: return s ? int'(ifb.first_fail_valid) : int'(ifa.first_fail_valid);
        endcase
    endfunction

    // Whether the modelled gate disagrees with the true function for pattern p
    function automatic bit mism(input int s, input int p);
        int  m;
        bit  r;
        m = s ? mode_b : mode_a;
        r = s ? ref_gate(FB, NB, p) : ref_gate(FA, NA, p);
        case (m)
            1:       return r == 1'b0;
            2:       return r == 1'b1;
            3:       return s ? mask_b[p] : mask_a[p];
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input int o, input int e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s != 0) ifb.start = v;
        else        ifa.start = v;
    endtask

    task automatic run(input int s, input bit mid, input bit exact);
        int n, lat, np, nf, first, last, exp_err, cyc;
        int seq[$];
        n = s ? NB : NA;  lat = s ? LB : LA;  np = 1 << n;
        nf = 0;  first = 0;  cyc = 0;
        for (int p = np - 1; p >= 0; p--) begin
            if (mism(s, p)) begin nf++; first = p; end
        end
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
        last    = (nf > 0) ? first : np - 1;
        exp_err = (nf > 0) ? 1 : 0;
`else
        last    = np - 1;
        exp_err = nf;
`endif
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        check("busy_rise", obs(s, K_BUSY), 1);
        check("done_clr",  obs(s, K_DONE), 0);
        check("err_clr",   obs(s, K_ERR),  0);
        check("stim_zero", obs(s, K_STIM), 0);
        while (obs(s, K_BUSY) == 1 && cyc < 400) begin
            if (seq.size() == 0 || seq[$] != obs(s, K_STIM)) seq.push_back(obs(s, K_STIM));
            cyc++;
            set_start(s, mid && (cyc == 3));
            @(negedge clk);
        end
        set_start(s, 1'b0);
        check("run_bounded", int'(cyc < 400), 1);
        check("done_set", obs(s, K_DONE), 1);
        if (exact) begin
            check("busy_len", cyc, (last + 1) * (2 + lat));
            check("err_count", obs(s, K_ERR), exp_err);
            check("pass", obs(s, K_PASS), int'(exp_err == 0));
            check("ff_valid", obs(s, K_FFVAL), int'(nf > 0));
            check("ff_vec", obs(s, K_FFV), (nf > 0) ? first : 0);
            check("seq_len", seq.size(), last + 1);
            foreach (seq[i]) check("seq_val", seq[i], i);
        end else begin
            check("pass_low", obs(s, K_PASS), 0);
            check("err_nonzero", int'(obs(s, K_ERR) > 0), 1);
        end
    endtask

    initial begin
        int cyc;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            for (int k = K_BUSY; k <= K_FFVAL; k++) check("reset_state", obs(s, k), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        mode_a = 0; run(0, 1'b0, 1'b1);
        mode_a = 0; run(0, 1'b1, 1'b1);
        mode_a = 1; run(0, 1'b0, 1'b1);
        mode_a = 2; run(0, 1'b0, 1'b1);
        mode_b = 0; del_b = 2; run(1, 1'b0, 1'b1);
        // A one-stage overrun still lands inside the hold window, so two extra stages are used
        mode_b = 0; del_b = 4; run(1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            mode_a = 3; mask_a = 4'($urandom);         run(0, 1'(r), 1'b1);
            mode_b = 3; del_b = 2; mask_b = 8'($urandom); run(1, 1'(r), 1'b1);
        end

        mode_a = 3; mask_a = 4'b0001;
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        cyc = 0;
        while (int'(ifa.stim) != 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_stim2", int'(ifa.stim), 2);
        check("err_before_rst", int'(ifa.err_count), 1);
        rst = 1'b1;
        set_start(0, 1'b1);
        @(negedge clk);
        for (int k = K_BUSY; k <= K_FFVAL; k++) check("midrun_reset", obs(0, k), 0);
        rst = 1'b0;
        set_start(0, 1'b0);
        @(negedge clk);
        check("idle_after_rst", int'(ifa.busy), 0);
        mode_a = 0; run(0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
